// File: rtl/cpu_pkg.sv
// Shared CPU definitions: pointer width, halt opcode, fetch states and the
// instruction-length rule used by fetch and decode alike.
package cpu_pkg;

  localparam int PTR_W = 5;
  localparam logic [7:0] HLT_OP = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_OP,
    FETCH_IMM,
    ISSUE,
    HALT
  } fetch_state_t;

  // An opcode with its top bit set carries one immediate byte after it.
  function automatic logic is_two_byte(input logic [7:0] op);
    return op[7];
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-to-decoder channel: instruction handshake plus branch redirect.
// The fetch unit is the master; the decoder is the slave.
interface instr_fetch_if #(
  parameter int PTR_W = cpu_pkg::PTR_W
);

  logic             instr_valid;
  logic             instr_ready;
  logic [7:0]       opcode;
  logic [7:0]       operand;
  logic             has_operand;
  logic             branch_en;
  logic [PTR_W-1:0] branch_target;

  modport master (
    output instr_valid, opcode, operand, has_operand,
    input  instr_ready, branch_en, branch_target
  );

  modport slave (
    input  instr_valid, opcode, operand, has_operand,
    output instr_ready, branch_en, branch_target
  );

endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: walks the program buffer, assembles one- or two-byte
// instructions, hands them to the decoder and follows branch redirects.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int         PTR_W  = cpu_pkg::PTR_W,
  parameter logic [7:0] HLT_OP = cpu_pkg::HLT_OP
) (
  input  logic             CPU_Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [PTR_W-1:0] prog_len,
  input  logic [7:0]       mem_data,
  output logic [PTR_W-1:0] pc,
  instr_fetch_if.master    dec,
  output logic             busy,
  output logic             halted,
  output logic             trunc_err
);

  fetch_state_t     state, state_next;
  logic [PTR_W-1:0] pc_next;
  logic [7:0]       opcode, opcode_next;
  logic [7:0]       operand, operand_next;
  logic             trunc_next;

  always_ff @(posedge CPU_Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      pc        <= '0;
      opcode    <= '0;
      operand   <= '0;
      trunc_err <= 1'b0;
    end else begin
      state     <= state_next;
      pc        <= pc_next;
      opcode    <= opcode_next;
      operand   <= operand_next;
      trunc_err <= trunc_next;
    end
  end

  always_comb begin
    state_next   = state;
    pc_next      = pc;
    opcode_next  = opcode;
    operand_next = operand;
    trunc_next   = trunc_err;

    case (state)
      IDLE: begin
        if (start) begin
          pc_next    = '0;
          state_next = FETCH_OP;
        end
      end

      FETCH_OP: begin
        // Running off the end of the loaded bytes is a normal program end.
        if (pc >= prog_len) begin
          trunc_next = 1'b0;
          state_next = HALT;
        end else begin
          opcode_next  = mem_data;
          operand_next = '0;
          pc_next      = pc + PTR_W'(1);
          state_next   = is_two_byte(mem_data) ? FETCH_IMM : ISSUE;
        end
      end

      FETCH_IMM: begin
        if (pc >= prog_len) begin
          trunc_next = 1'b1;
          state_next = HALT;
        end else begin
          operand_next = mem_data;
          pc_next      = pc + PTR_W'(1);
          state_next   = ISSUE;
        end
      end

      ISSUE: begin
        // Halt wins over a redirect offered alongside it.
        if (dec.instr_ready) begin
          if (opcode == HLT_OP) begin
            state_next = HALT;
          end else begin
            if (dec.branch_en) pc_next = dec.branch_target;
            state_next = FETCH_OP;
          end
        end
      end

      HALT: begin
        if (start) begin
          trunc_next = 1'b0;
          pc_next    = '0;
          state_next = FETCH_OP;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign dec.instr_valid = (state == ISSUE);
  assign dec.opcode      = opcode;
  assign dec.operand     = operand;
  assign dec.has_operand = is_two_byte(opcode);
  assign busy            = (state != IDLE) && (state != HALT);
  assign halted          = (state == HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// Randomised self-checking bench for instr_fetch against a byte-level program
// walker that predicts each issued instruction and how the program ends.
module tb_instr_fetch;

  logic       CPU_Clk;
  logic       Reset;
  logic       start;
  logic [4:0] prog_len;
  logic [7:0] mem_data;
  logic [4:0] pc;
  logic       busy, halted, trunc_err;
  logic [7:0] mem [32];

  int compared = 0;
  int mismatched = 0;

  instr_fetch_if dec_bus ();

  instr_fetch dut (
    .CPU_Clk  (CPU_Clk),
    .Reset    (Reset),
    .start    (start),
    .prog_len (prog_len),
    .mem_data (mem_data),
    .pc       (pc),
    .dec      (dec_bus),
    .busy     (busy),
    .halted   (halted),
    .trunc_err(trunc_err)
  );

  assign mem_data = mem[pc];

  initial CPU_Clk = 1'b0;
  always #5 CPU_Clk = ~CPU_Clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_pc"}, 32'(pc), 0);
    check_output({tag, "_valid"}, 32'(dec_bus.instr_valid), 0);
    check_output({tag, "_opcode"}, 32'(dec_bus.opcode), 0);
    check_output({tag, "_operand"}, 32'(dec_bus.operand), 0);
    check_output({tag, "_busy"}, 32'(busy), 0);
    check_output({tag, "_halted"}, 32'(halted), 0);
    check_output({tag, "_trunc"}, 32'(trunc_err), 0);
  endtask

  task automatic pulse_reset();
    #1 Reset = 1'b1;
    #1 Reset = 1'b0;
  endtask

  // Starts the loaded program and walks it byte by byte, predicting every
  // issue, stall behaviour, redirect and the final halt.
  task automatic apply_stimulus(input int min_stall, input int max_stall, input int branch_pct,
                                input int tgt_max, input int max_issues);
    int  pc_m, pc_seq, len, n, cyc, lat;
    logic [7:0] op, imm;
    bit  done, two, br;
    pc_m = 0;
    n    = 0;
    done = 0;
    len  = int'(prog_len);
    start = 1'b1;
    @(negedge CPU_Clk);
    start = 1'b0;
    check_output("start_clears_trunc", 32'(trunc_err), 0);
    while (!done) begin
      cyc = 1;
      if (pc_m >= len || (mem[pc_m][7] && pc_m + 1 >= len)) begin
        two = (pc_m < len);
        lat = two ? 3 : 2;
        while (!halted && !dec_bus.instr_valid && cyc < 10) begin
          @(negedge CPU_Clk);
          cyc++;
        end
        check_output("halt_latency", 32'(cyc), 32'(lat));
        check_output("halt_no_valid", 32'(dec_bus.instr_valid), 0);
        check_output("halted", 32'(halted), 1);
        check_output("halt_trunc", 32'(trunc_err), 32'(two));
        check_output("halt_pc", 32'(pc), 32'(two ? pc_m + 1 : pc_m));
        check_output("halt_busy", 32'(busy), 0);
        done = 1;
      end else begin
        op     = mem[pc_m];
        two    = op[7];
        imm    = two ? mem[pc_m + 1] : 8'h00;
        pc_seq = pc_m + (two ? 2 : 1);
        lat    = two ? 3 : 2;
        while (!dec_bus.instr_valid && cyc < 10) begin
          @(negedge CPU_Clk);
          cyc++;
        end
        check_output("issue_latency", 32'(cyc), 32'(lat));
        check_output("issue_opcode", 32'(dec_bus.opcode), 32'(op));
        check_output("issue_operand", 32'(dec_bus.operand), 32'(imm));
        check_output("issue_has_operand", 32'(dec_bus.has_operand), 32'(two));
        check_output("issue_pc", 32'(pc), 32'(pc_seq));
        if (!dec_bus.instr_valid) begin
          pulse_reset();
          @(negedge CPU_Clk);
          done = 1;
        end else begin
          for (int s = 0; s < $urandom_range(max_stall, min_stall); s++) begin
            dec_bus.instr_ready   = 1'b0;
            dec_bus.branch_en     = 1'b1;
            dec_bus.branch_target = 5'($urandom_range(31, 0));
            @(negedge CPU_Clk);
            check_output("stall_valid", 32'(dec_bus.instr_valid), 1);
            check_output("stall_opcode", 32'(dec_bus.opcode), 32'(op));
            check_output("stall_pc", 32'(pc), 32'(pc_seq));
          end
          br = ($urandom_range(99, 0) < branch_pct);
          dec_bus.instr_ready   = 1'b1;
          dec_bus.branch_en     = br;
          dec_bus.branch_target = 5'($urandom_range(tgt_max, 0));
          pc_m = br ? int'(dec_bus.branch_target) : pc_seq;
          @(negedge CPU_Clk);
          dec_bus.instr_ready = 1'b0;
          dec_bus.branch_en   = 1'b0;
          n++;
          if (op == 8'hFF) begin
            check_output("hlt_halted", 32'(halted), 1);
            check_output("hlt_pc", 32'(pc), 32'(pc_seq));
            check_output("hlt_trunc", 32'(trunc_err), 0);
            done = 1;
          end else begin
            check_output("accept_pc", 32'(pc), 32'(pc_m));
            if (n >= max_issues) begin
              pulse_reset();
              @(negedge CPU_Clk);
              done = 1;
            end
          end
        end
      end
    end
  endtask

  task automatic load_program(input int len);
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom_range(255, 0));
    prog_len = 5'(len);
  endtask

  initial begin
    Reset = 1'b1;
    start = 1'b0;
    prog_len = '0;
    dec_bus.instr_ready   = 1'b0;
    dec_bus.branch_en     = 1'b0;
    dec_bus.branch_target = '0;
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    #1 check_reset_values("reset");
    @(negedge CPU_Clk);
    Reset = 1'b0;
    @(negedge CPU_Clk);

    $display("[TB] two one-byte instructions");
    load_program(2);
    mem[0] = 8'h01; mem[1] = 8'h02;
    apply_stimulus(0, 0, 0, 31, 40);

    $display("[TB] immediate then halt opcode");
    load_program(4);
    mem[0] = 8'h85; mem[1] = 8'h3C; mem[2] = 8'hFF; mem[3] = 8'h00;
    apply_stimulus(0, 0, 0, 31, 40);

    $display("[TB] halt opcode missing its operand byte");
    load_program(3);
    mem[0] = 8'h85; mem[1] = 8'h3C; mem[2] = 8'hFF;
    apply_stimulus(0, 0, 0, 31, 40);

    $display("[TB] truncated single instruction, then restart");
    load_program(1);
    mem[0] = 8'h90;
    apply_stimulus(0, 0, 0, 31, 40);
    load_program(0);
    apply_stimulus(0, 0, 0, 31, 40);

    $display("[TB] stalls with redirect noise");
    load_program(4);
    mem[0] = 8'h01; mem[1] = 8'h82; mem[2] = 8'h33; mem[3] = 8'h04;
    apply_stimulus(5, 5, 0, 31, 40);

    $display("[TB] branches within a short program");
    load_program(6);
    for (int i = 0; i < 6; i++) mem[i] = 8'(i + 1);
    apply_stimulus(0, 2, 100, 7, 12);
    apply_stimulus(0, 0, 100, 31, 12);

    $display("[TB] reset during operand fetch");
    load_program(2);
    mem[0] = 8'h90; mem[1] = 8'h11;
    start = 1'b1;
    @(negedge CPU_Clk);
    start = 1'b0;
    @(negedge CPU_Clk);
    check_output("imm_busy", 32'(busy), 1);
    check_output("imm_pc", 32'(pc), 1);
    #1 Reset = 1'b1;
    #1 check_reset_values("async_reset");
    Reset = 1'b0;
    @(negedge CPU_Clk);
    apply_stimulus(0, 0, 0, 31, 40);

    $display("[TB] random programs");
    for (int t = 0; t < 25; t++) begin
      load_program($urandom_range(31, 0));
      for (int i = 0; i < 32; i++) if ($urandom_range(7, 0) == 0) mem[i] = 8'hFF;
      apply_stimulus(0, 3, 30, 31, 40);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
